arithmetic_fu_pipe: RTL and testbench



---
 rtl/arithmetic_fu_pipe.sv | 161 ++++++++++++++++
 tb/tb_arithmetic_fu_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/arithmetic_fu_pipe.sv
// -----------------------------------------------------------------------------
// arithmetic_fu_pipe
//
// Pipelined integer arithmetic functional unit. A uop is evaluated
// combinationally on entry and captured into stage 0. Stages 1..STAGES-1 only
// hold {valid, result, illegal, rob tag, dest tag}. Valid/ready handshakes on
// both sides give backpressure, and the stages collapse bubbles. A flush
// squashes everything in flight plus the uop offered in the same cycle.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst_n         asynchronous active-low reset
//   flush         synchronous squash of in-flight and incoming uops
//   valid_in      issue request
//   ready_out     FU can accept a uop this cycle (0 while in reset)
//   uop           operation select
//                 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 LUI, 5 AUIPC
//                 any other value is illegal
//   rob_entry_in  ROB tag of the incoming uop
//   dest_reg_in   physical destination tag of the incoming uop
//   rs1, rs2, pc  operands; rs2 carries the immediate for LUI/AUIPC
//   valid_out     result available (gated by flush)
//   ready_in      writeback arbiter accepts the result this cycle
//   result        computed value
//   rob_entry     ROB tag of the result
//   dest_reg      destination tag of the result
//   illegal       the uop was not a defined encoding
// -----------------------------------------------------------------------------
module arithmetic_fu_pipe #(
    parameter int XLEN          = 32,
    parameter int ROB_SIZE      = 256,
    parameter int PHYS_REG_SIZE = 256,
    parameter int UOP_SIZE      = 16,
    parameter int STAGES        = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             valid_in,
    output logic                             ready_out,
    input  logic [$clog2(UOP_SIZE)-1:0]      uop,
    input  logic [$clog2(ROB_SIZE)-1:0]      rob_entry_in,
    input  logic [$clog2(PHYS_REG_SIZE)-1:0] dest_reg_in,
    input  logic [XLEN-1:0]                  rs1,
    input  logic [XLEN-1:0]                  rs2,
    input  logic [XLEN-1:0]                  pc,
    output logic                             valid_out,
    input  logic                             ready_in,
    output logic [XLEN-1:0]                  result,
    output logic [$clog2(ROB_SIZE)-1:0]      rob_entry,
    output logic [$clog2(PHYS_REG_SIZE)-1:0] dest_reg,
    output logic                             illegal
);

    localparam int UW = $clog2(UOP_SIZE);
    localparam int RW = $clog2(ROB_SIZE);
    localparam int PW = $clog2(PHYS_REG_SIZE);

    // Per-stage state
    logic            valid_reg   [STAGES];
    logic [XLEN-1:0] result_reg  [STAGES];
    logic            illegal_reg [STAGES];
    logic [RW-1:0]   rob_reg     [STAGES];
    logic [PW-1:0]   dest_tag_reg[STAGES];

    // advance[i]: stage i hands its contents downstream (or retires) this cycle
    logic [STAGES-1:0] advance;

    // Entry compute
    logic [XLEN-1:0] calc_result;
    logic            calc_illegal;
    logic            accept;

    always_comb begin
        calc_result  = '0;
        calc_illegal = 1'b0;
        // Anything above AUIPC (including any set upper bit) is undefined.
        if (uop > UW'(5)) begin
            calc_illegal = 1'b1;
        end else begin
            case (uop[2:0])
                3'd0:    calc_result = rs1 + rs2;
                3'd1:    calc_result = rs1 - rs2;
                3'd2:    calc_result = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
                3'd3:    calc_result = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
                3'd4:    calc_result = rs2;
                3'd5:    calc_result = pc + rs2;
                default: calc_illegal = 1'b1;
            endcase
        end
    end

    // Bubble-collapsing ready chain, evaluated from the output backwards so the
    // last stage's ready_in propagates all the way to ready_out in one cycle.
    always_comb begin
        advance = '0;
        advance[STAGES-1] = ready_in || !valid_reg[STAGES-1];
        for (int i = STAGES - 2; i >= 0; i--) begin
            advance[i] = !valid_reg[i+1] || advance[i+1];
        end
    end

    // rst_n gates ready_out so nothing is offered as accepted while in reset.
    assign ready_out = rst_n && (!valid_reg[0] || advance[0]);
    assign accept    = valid_in && ready_out && !flush;

    // Stage 0: captures the freshly computed uop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg[0]    <= 1'b0;
            result_reg[0]   <= '0;
            illegal_reg[0]  <= 1'b0;
            rob_reg[0]      <= '0;
            dest_tag_reg[0] <= '0;
        end else if (flush) begin
            valid_reg[0] <= 1'b0;
        end else if (ready_out) begin
            valid_reg[0] <= accept;
            if (accept) begin
                result_reg[0]   <= calc_result;
                illegal_reg[0]  <= calc_illegal;
                rob_reg[0]      <= rob_entry_in;
                dest_tag_reg[0] <= dest_reg_in;
            end
        end
    end

    // Stages 1..STAGES-1: pure holding registers
    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg[gi]    <= 1'b0;
                    result_reg[gi]   <= '0;
                    illegal_reg[gi]  <= 1'b0;
                    rob_reg[gi]      <= '0;
                    dest_tag_reg[gi] <= '0;
                end else if (flush) begin
                    valid_reg[gi] <= 1'b0;
                end else if (advance[gi-1]) begin
                    // Upstream moves into us; a stalled stage keeps every field.
                    valid_reg[gi] <= valid_reg[gi-1];
                    if (valid_reg[gi-1]) begin
                        result_reg[gi]   <= result_reg[gi-1];
                        illegal_reg[gi]  <= illegal_reg[gi-1];
                        rob_reg[gi]      <= rob_reg[gi-1];
                        dest_tag_reg[gi] <= dest_tag_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Flush masks the output so no result retires in a flush cycle.
    assign valid_out = valid_reg[STAGES-1] && !flush;
    assign result    = result_reg[STAGES-1];
    assign illegal   = illegal_reg[STAGES-1];
    assign rob_entry = rob_reg[STAGES-1];
    assign dest_reg  = dest_tag_reg[STAGES-1];

endmodule

// File: tb/tb_arithmetic_fu_pipe.sv
module tb_arithmetic_fu_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        valid_in;
    logic        ready_out;
    logic [3:0]  uop;
    logic [7:0]  rob_entry_in;
    logic [7:0]  dest_reg_in;
    logic [31:0] rs1, rs2, pc;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] result;
    logic [7:0]  rob_entry;
    logic [7:0]  dest_reg;
    logic        illegal;

    int tests  = 0;
    int failed = 0;
    int accepts;

    arithmetic_fu_pipe #(
        .XLEN(32), .ROB_SIZE(256), .PHYS_REG_SIZE(256), .UOP_SIZE(16), .STAGES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .valid_in(valid_in), .ready_out(ready_out), .uop(uop),
        .rob_entry_in(rob_entry_in), .dest_reg_in(dest_reg_in),
        .rs1(rs1), .rs2(rs2), .pc(pc),
        .valid_out(valid_out), .ready_in(ready_in), .result(result),
        .rob_entry(rob_entry), .dest_reg(dest_reg), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full output check of a valid result
    task automatic chk_out(input string tag, input logic [31:0] res, input logic ill,
                           input logic [7:0] rob, input logic [7:0] dst);
        chk({tag, ".valid"}, {31'd0, valid_out}, 32'd1);
        chk({tag, ".result"}, result, res);
        chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, ill});
        chk({tag, ".rob"}, {24'd0, rob_entry}, {24'd0, rob});
        chk({tag, ".dest"}, {24'd0, dest_reg}, {24'd0, dst});
        $display("[TB] %s result=%0h illegal=%0b rob=%0d dest=%0d", tag, result, illegal, rob_entry, dest_reg);
    endtask

    task automatic issue(input logic [3:0] u, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [7:0] rob, input logic [7:0] dst);
        valid_in = 1'b1; uop = u; rs1 = a; rs2 = b; pc = p;
        rob_entry_in = rob; dest_reg_in = dst;
    endtask

    task automatic idle();
        valid_in = 1'b0; uop = 4'd0; rs1 = '0; rs2 = '0; pc = '0;
        rob_entry_in = '0; dest_reg_in = '0;
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 3 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; ready_in = 1'b1;
        idle();

        // ---------------- reset / idle ----------------
        tick(); tick();
        settle();
        chk("rst.valid_out", {31'd0, valid_out}, 32'd0);
        chk("rst.result", result, 32'd0);
        chk("rst.ready_out", {31'd0, ready_out}, 32'd0);
        chk("rst.illegal", {31'd0, illegal}, 32'd0);
        $display("[TB] reset: valid_out=%0b ready_out=%0b", valid_out, ready_out);
        tick();
        rst_n = 1'b1;

        // ---------------- back-to-back ops ----------------
        issue(4'd0, 32'd5, 32'd7, 32'd0, 8'd1, 8'd11);
        settle();
        chk("idle.ready_out", {31'd0, ready_out}, 32'd1);
        chk("add.lat0", {31'd0, valid_out}, 32'd0);
        tick();
        issue(4'd1, 32'd3, 32'd5, 32'd0, 8'd2, 8'd12);
        settle();
        chk("add.lat1", {31'd0, valid_out}, 32'd0);
        tick();
        issue(4'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 8'd3, 8'd13);
        settle(); chk_out("add", 32'd12, 1'b0, 8'd1, 8'd11);
        tick();
        issue(4'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 8'd4, 8'd14);
        settle(); chk_out("sub", 32'hFFFF_FFFE, 1'b0, 8'd2, 8'd12);
        tick();
        issue(4'd4, 32'd0, 32'h1234_5000, 32'd0, 8'd5, 8'd15);
        settle(); chk_out("slt", 32'd1, 1'b0, 8'd3, 8'd13);
        tick();
        issue(4'd5, 32'd0, 32'h2000, 32'h1000, 8'd6, 8'd16);
        settle(); chk_out("sltu", 32'd0, 1'b0, 8'd4, 8'd14);
        tick();
        issue(4'd7, 32'd9, 32'd9, 32'd0, 8'd7, 8'd17);
        settle(); chk_out("lui", 32'h1234_5000, 1'b0, 8'd5, 8'd15);
        tick();
        idle();
        settle(); chk_out("auipc", 32'h3000, 1'b0, 8'd6, 8'd16);
        tick();
        settle(); chk_out("illegal7", 32'd0, 1'b1, 8'd7, 8'd17);
        tick();
        settle();
        chk("drain.empty", {31'd0, valid_out}, 32'd0);
        tick();

        // ---------------- backpressure ----------------
        ready_in = 1'b0;
        accepts = 0;
        for (int k = 0; k < 5; k++) begin
            issue(4'd0, 32'd100 + 32'(accepts), 32'd0, 32'd0, 8'(20 + accepts), 8'(40 + accepts));
            settle();
            if (k >= 2) begin
                chk("bp.ready_out", {31'd0, ready_out}, 32'd0);
                chk_out("bp.hold", 32'd100, 1'b0, 8'd20, 8'd40);
            end
            if (ready_out) accepts++;
            tick();
        end
        chk("bp.accepts", 32'(accepts), 32'd2);
        idle();
        ready_in = 1'b1;
        settle();
        chk("bp.ready_release", {31'd0, ready_out}, 32'd1);
        chk_out("bp.drain0", 32'd100, 1'b0, 8'd20, 8'd40);
        tick();
        settle(); chk_out("bp.drain1", 32'd101, 1'b0, 8'd21, 8'd41);
        tick();
        settle();
        chk("bp.empty", {31'd0, valid_out}, 32'd0);
        tick();

        // ---------------- retire + accept in a full pipe ----------------
        ready_in = 1'b0;
        issue(4'd0, 32'd10, 32'd1, 32'd0, 8'd40, 8'd60); tick();
        issue(4'd0, 32'd20, 32'd1, 32'd0, 8'd41, 8'd61); tick();
        issue(4'd1, 32'd30, 32'd1, 32'd0, 8'd42, 8'd62);
        settle();
        chk("full.ready_stall", {31'd0, ready_out}, 32'd0);
        ready_in = 1'b1;
        #1;
        chk("full.ready_pass", {31'd0, ready_out}, 32'd1);
        chk_out("full.r0", 32'd11, 1'b0, 8'd40, 8'd60);
        tick();
        idle();
        settle(); chk_out("full.r1", 32'd21, 1'b0, 8'd41, 8'd61);
        tick();
        settle(); chk_out("full.r2", 32'd29, 1'b0, 8'd42, 8'd62);
        tick();
        settle();
        chk("full.empty", {31'd0, valid_out}, 32'd0);
        tick();

        // ---------------- flush ----------------
        ready_in = 1'b0;
        issue(4'd0, 32'd1, 32'd1, 32'd0, 8'd30, 8'd50); tick();
        issue(4'd0, 32'd2, 32'd2, 32'd0, 8'd31, 8'd51); tick();
        issue(4'd0, 32'd40, 32'd2, 32'd0, 8'd32, 8'd52);
        ready_in = 1'b1;
        flush = 1'b1;
        settle();
        chk("flush.no_retire", {31'd0, valid_out}, 32'd0);
        $display("[TB] flush cycle: valid_out=%0b", valid_out);
        tick();
        flush = 1'b0;
        idle();
        settle();
        chk("flush.next", {31'd0, valid_out}, 32'd0);
        chk("flush.ready", {31'd0, ready_out}, 32'd1);
        tick();
        settle();
        chk("flush.dropped1", {31'd0, valid_out}, 32'd0);
        tick();
        settle();
        chk("flush.dropped2", {31'd0, valid_out}, 32'd0);
        tick();

        // ---------------- async reset mid-stream ----------------
        issue(4'd0, 32'd7, 32'd7, 32'd0, 8'd50, 8'd70); tick();
        issue(4'd0, 32'd8, 32'd8, 32'd0, 8'd51, 8'd71); tick();
        idle();
        ready_in = 1'b0;
        settle();
        chk_out("arst.before", 32'd14, 1'b0, 8'd50, 8'd70);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst.valid_out", {31'd0, valid_out}, 32'd0);
        chk("arst.ready_out", {31'd0, ready_out}, 32'd0);
        chk("arst.result", result, 32'd0);
        $display("[TB] async reset: valid_out=%0b result=%0h", valid_out, result);
        tick(); tick();
        rst_n = 1'b1;
        ready_in = 1'b1;
        settle();
        chk("arst.release_ready", {31'd0, ready_out}, 32'd1);
        chk("arst.release_valid", {31'd0, valid_out}, 32'd0);
        tick();
        settle();
        chk("arst.no_stale1", {31'd0, valid_out}, 32'd0);
        tick();
        settle();
        chk("arst.no_stale2", {31'd0, valid_out}, 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
